pc_sequencer: RTL
=================

# pc_sequencer

Owns the fetch program counter and decides each cycle's next PC: sequential `PC+2`, conditional branch (immediate or register target), stall hold, or halt. It holds the Z/V/N flag register that branch conditions test, with same-cycle forwarding from the ALU. It drives the IF/ID flush on taken branches and counts taken branches for performance monitoring. It sits between the decode stage (branch/halt/stall inputs) and instruction memory (`pc` output).

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk` in 1: system clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard stall; holds PC and state.
- `halt` in 1: HLT decoded this cycle.
- `br_valid` in 1: branch instruction in decode this cycle.
- `br_reg` in 1: 1 = BR (register target), 0 = B (immediate target); meaningful only with `br_valid`.
- `cond` in 3: branch condition code.
- `imm` in 9: signed word offset for B.
- `br_pc_plus2` in 16: address of the branch instruction + 2, taken from IF/ID.
- `reg_target` in 16: target address for BR.
- `flag_wr` in 3: per-flag write enables; bit0 Z, bit1 V, bit2 N.
- `flag_in` in 3: new flag values from the ALU, same bit order.
- `pc` out 16: current fetch address (registered).
- `pc_plus2` out 16: `pc + 2` mod 2^16 (combinational).
- `flush` out 1: squash IF/ID this cycle (combinational).
- `flags` out 3: registered {N,V,Z}.
- `halted` out 1: high in state HALTED.
- `taken_cnt` out 16: saturating count of taken branches.

## Operation
- **FSM states:**
  - RUN: normal operation.
  - HALTED: terminal until `rst`.
- **Effective flags** `eflags`: bit i = `flag_in[i]` if `flag_wr[i]`, else `flags[i]`. Branch evaluation always uses `eflags`.
- **Condition codes** (taken when the listed test is true):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OVF: V=1
  - 111 unconditional
- **Targets:**
  - B: `br_pc_plus2 + ({{6{imm[8]}}, imm, 1'b0})`, sign-extended, mod 2^16.
  - BR: `reg_target`, used as-is. Bit 0 is not masked.
- `take = br_valid & cond_true`, evaluated in RUN only.
- **Next-PC priority, highest first:**
  1. `rst`: pc←RESET_PC, flags←0, taken_cnt←0, state←RUN.
  2. HALTED: pc, flags and taken_cnt hold. All inputs are ignored.
  3. `stall`: pc holds. Branch and halt are ignored this cycle; decode re-presents them.
  4. `halt`: pc holds, state←HALTED.
  5. `take`: pc←target, taken_cnt←taken_cnt+1, saturating at 16'hFFFF.
  6. Otherwise pc←pc+2, wrapping 16'hFFFE→16'h0000.
- **Flag register:** `flags[i]`←`flag_in[i]` when `flag_wr[i]`, in RUN, even during `stall`. Flags freeze in HALTED.
- **`flush`:** equals `take & ~stall` in RUN, else 0. It is never asserted by `halt`.
- A not-taken `br_valid` behaves as case 6 with no flush.
- A taken branch whose target equals the current `pc` is legal; `flush` is still asserted.

## Timing
- **Reset values:** pc=RESET_PC, pc_plus2=RESET_PC+2, flags=3'b000, halted=0, flush=0, taken_cnt=0.
- **PC update:** new PC appears on `pc` one cycle after the deciding edge. Branch penalty is exactly one flushed fetch.
- **Combinational outputs:** `flush` and `pc_plus2` follow their inputs within the same cycle. No input-to-`pc` combinational path exists.
- **Halt:** `halted` rises the cycle after `halt` is sampled. `pc` stays at the halt-cycle value.
- **Same-edge flag write and branch:** the branch sees the new flag values via forwarding; the flag register updates on that same edge.
- **`rst` during HALTED or mid-stall:** the next cycle is the reset state.

## Test plan
- **Reset and sequential run:** assert `rst` 2 cycles, release, no other inputs. Expect pc=0000, 0002, 0004, 0006 on successive cycles; `halted`=0, `flush`=0.
- **B EQ forwarding:** flags=000, same cycle `flag_wr`=001, `flag_in`=001, `br_valid`=1, `cond`=001, `imm`=9'h1FE (−2), `br_pc_plus2`=0010. Expect `flush`=1 that cycle, next pc=000C, flags=001, taken_cnt=1.
- **BR not-taken vs taken:**
  - flags={N=0,V=0,Z=1}, `cond`=000, `br_reg`=1, `reg_target`=1234. Expect no flush, pc+2.
  - Repeat with `cond`=111. Expect pc=1234.
- **Stall priority and wrap:** pc=FFFE, `stall`=1 with a taken branch. Expect pc holds FFFE, `flush`=0. Drop `stall` with no branch. Expect pc=0000.
- **Halt:** `halt`=1 at pc=0040. Expect `halted`=1 next cycle, pc stays 0040 for 5 cycles despite `br_valid`/`cond`=111. Then `rst` gives pc=0000, `halted`=0.
- **Counter saturation:** preload via 65535 taken unconditional branches, then 2 more. Expect taken_cnt=FFFF.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter and next-PC selection.
//
// Picks each cycle's next fetch address: sequential pc+2, conditional branch
// (immediate or register target), stall hold or halt. Holds the {N,V,Z} flag
// register that branch conditions test. ALU flag writes are forwarded into
// branch evaluation in the same cycle. Drives the IF/ID flush on taken
// branches and keeps a saturating count of taken branches.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hazard stall; holds pc, drops branch/halt this cycle
//   halt         in   HLT decoded this cycle
//   br_valid     in   branch in decode this cycle
//   br_reg       in   1 = BR (register target), 0 = B (immediate target)
//   cond         in   [2:0] branch condition code
//   imm          in   [8:0] signed word offset for B
//   br_pc_plus2  in   [15:0] branch instruction address + 2
//   reg_target   in   [15:0] BR target address
//   flag_wr      in   [2:0] per-flag write enables {N,V,Z}
//   flag_in      in   [2:0] new flag values {N,V,Z}
//   pc           out  [15:0] current fetch address (registered)
//   pc_plus2     out  [15:0] pc + 2 (combinational)
//   flush        out  squash IF/ID this cycle (combinational)
//   flags        out  [2:0] registered {N,V,Z}
//   halted       out  high once halted, until reset
//   taken_cnt    out  [15:0] saturating taken-branch count

module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        halt,
   input  logic        br_valid,
   input  logic        br_reg,
   input  logic [2:0]  cond,
   input  logic [8:0]  imm,
   input  logic [15:0] br_pc_plus2,
   input  logic [15:0] reg_target,
   input  logic [2:0]  flag_wr,
   input  logic [2:0]  flag_in,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        flush,
   output logic [2:0]  flags,
   output logic        halted,
   output logic [15:0] taken_cnt
);

   typedef enum logic [0:0] {StRun, StHalted} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [2:0]  flags_q, flags_d;
   logic [15:0] cnt_q, cnt_d;

   logic [2:0]  eflags;
   logic        z_flag, v_flag, n_flag;
   logic        cond_true;
   logic [15:0] br_offset;
   logic [15:0] target;
   logic        take;

   // Forward same-cycle ALU flag writes so a branch sees them immediately.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         eflags[i] = flag_wr[i] ? flag_in[i] : flags_q[i];
      end
   end

   assign z_flag = eflags[0];
   assign v_flag = eflags[1];
   assign n_flag = eflags[2];

   always_comb begin
      cond_true = 1'b0;
      unique case (cond)
         3'b000:  cond_true = ~z_flag;
         3'b001:  cond_true = z_flag;
         3'b010:  cond_true = ~z_flag & ~n_flag;
         3'b011:  cond_true = n_flag;
         3'b100:  cond_true = z_flag | (~z_flag & ~n_flag);
         3'b101:  cond_true = n_flag | z_flag;
         3'b110:  cond_true = v_flag;
         3'b111:  cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // Word offset scaled to bytes; BR target bit 0 is deliberately unmasked.
   assign br_offset = {{6{imm[8]}}, imm, 1'b0};
   assign target    = br_reg ? reg_target : (br_pc_plus2 + br_offset);

   assign take     = (state_q == StRun) & br_valid & cond_true;
   assign flush    = take & ~stall;
   assign pc_plus2 = pc_q + 16'd2;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flags_d = flags_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            // Flag writes land even while stalled or halting.
            flags_d = eflags;
            if (stall) begin
               pc_d = pc_q;
            end else if (halt) begin
               state_d = StHalted;
            end else if (take) begin
               pc_d  = target;
               cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end else begin
               pc_d = pc_plus2;
            end
         end
         StHalted: begin
            state_d = StHalted;
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         flags_q <= 3'b000;
         cnt_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc        = pc_q;
   assign flags     = flags_q;
   assign halted    = (state_q == StHalted);
   assign taken_cnt = cnt_q;

endmodule
